// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - size codes, FSM states and lane helpers for the memory stage
package mips_mem_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    WORD = 2'b01,
    HALF = 2'b10,
    BYTE = 2'b11
  } ls_size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  function automatic logic is_aligned(input ls_size_e size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      WORD:    ok = (addr_lo == 2'b00);
      HALF:    ok = !addr_lo[0];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enables(input ls_size_e size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      WORD:    be = 4'b1111;
      HALF:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      BYTE:    be = 4'b0001 << addr_lo;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data is copied into every lane so the byte enables alone pick the target.
  function automatic logic [31:0] replicate_wdata(input ls_size_e size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      WORD:    wd = data;
      HALF:    wd = {2{data[15:0]}};
      BYTE:    wd = {4{data[7:0]}};
      default: wd = 32'h0;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] load_extract(input ls_size_e size, input logic ext_op,
                                               input logic [1:0] addr_lo, input logic [31:0] rdata);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    case (size)
      WORD:    res = rdata;
      HALF:    res = {{16{ext_op & half_v[15]}}, half_v};
      BYTE:    res = {{24{ext_op & byte_v[7]}}, byte_v};
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - lane select and sign/zero extension of a loaded word
import mips_mem_pkg::*;

module mem_load_align (
  input  ls_size_e    size,
  input  logic        ext_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  assign data = load_extract(size, ext_op, addr_lo, rdata);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage request/ready controller with stall and error flags
import mips_mem_pkg::*;

module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        EX_MEM_valid,
  input  logic [1:0]  EX_MEM_LS_bit,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_Ext_op,
  input  logic [31:0] EX_MEM_mux5_out,
  input  logic [31:0] EX_MEM_mux3_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_err,
  output logic [31:0] bad_addr,
  output logic        bus_err
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic        bus_err_q, bus_err_d;
  ls_size_e    size_q, size_d;
  logic        ext_q, ext_d;
  logic [1:0]  alo_q, alo_d;

  ls_size_e    size_in;
  logic        access_req;
  logic        aligned;
  logic        in_idle;
  logic        in_access;
  logic        issue;
  logic        misalign;
  logic        timeout_hit;
  logic [31:0] align_data;

  assign size_in    = ls_size_e'(EX_MEM_LS_bit);
  assign access_req = EX_MEM_valid && (size_in != NONE);
  assign aligned    = is_aligned(size_in, EX_MEM_mux5_out[1:0]);
  assign in_idle    = (state_q == ST_IDLE);
  assign in_access  = (state_q == ST_ACCESS);
  assign issue      = in_idle && access_req && aligned;
  assign misalign   = in_idle && access_req && !aligned;
  assign timeout_hit = in_access && !mem_ready && (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (issue) state_d = ST_ACCESS;
      ST_ACCESS: if (mem_ready || timeout_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Combinational outputs; all forced low while reset is asserted
  always_comb begin
    stall      = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'h0;
    if (!reset) begin
      stall      = issue || (in_access && !mem_ready && !timeout_hit);
      load_valid = in_access && mem_ready && !mem_we_q;
      load_data  = load_valid ? align_data : 32'h0;
    end
  end

  mem_load_align u_load_align (
    .size    (size_q),
    .ext_op  (ext_q),
    .addr_lo (alo_q),
    .rdata   (mem_rdata),
    .data    (align_data)
  );

  // Request fields hold across wait states; flags are single-cycle pulses.
  always_comb begin
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    addr_err_d  = 1'b0;
    bad_addr_d  = bad_addr_q;
    bus_err_d   = 1'b0;
    size_d      = size_q;
    ext_d       = ext_q;
    alo_d       = alo_q;

    if (issue) begin
      mem_req_d   = 1'b1;
      mem_we_d    = EX_MEM_MemWrite;
      mem_addr_d  = {EX_MEM_mux5_out[31:2], 2'b00};
      mem_wdata_d = replicate_wdata(size_in, EX_MEM_mux3_out);
      mem_be_d    = byte_enables(size_in, EX_MEM_mux5_out[1:0]);
      size_d      = size_in;
      ext_d       = EX_MEM_Ext_op;
      alo_d       = EX_MEM_mux5_out[1:0];
      cnt_d       = 32'h0;
    end

    if (misalign) begin
      addr_err_d = 1'b1;
      bad_addr_d = EX_MEM_mux5_out;
    end

    if (in_access) begin
      if (mem_ready) begin
        mem_req_d = 1'b0;
        cnt_d     = 32'h0;
      end else if (timeout_hit) begin
        mem_req_d = 1'b0;
        cnt_d     = 32'h0;
        bus_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'h1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      addr_err_q  <= 1'b0;
      bad_addr_q  <= 32'h0;
      bus_err_q   <= 1'b0;
      size_q      <= NONE;
      ext_q       <= 1'b0;
      alo_q       <= 2'b00;
    end else begin
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      addr_err_q  <= addr_err_d;
      bad_addr_q  <= bad_addr_d;
      bus_err_q   <= bus_err_d;
      size_q      <= size_d;
      ext_q       <= ext_d;
      alo_q       <= alo_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign addr_err  = addr_err_q;
  assign bad_addr  = bad_addr_q;
  assign bus_err   = bus_err_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage access controller between the EX/MEM pipeline register and the data memory port.
- Checks alignment and turns LS_bit/MemWrite/Ext_op into a request/ready transaction with lane-replicated write data and byte enables.
- Extracts and extends load data.
- Stalls the pipeline while an access is outstanding and raises address-error and bus-timeout flags.

Parameters:
NONE, 2'b00, no memory access
WORD, 2'b01, 32-bit access
HALF, 2'b10, 16-bit access
BYTE, 2'b11, 8-bit access
TIMEOUT, 16, max ACCESS cycles waiting for mem_ready before bus error; 0 disables timeout

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
EX_MEM_valid  input  1  EX/MEM slot holds a live instruction
EX_MEM_LS_bit  input  2  access size (NONE/WORD/HALF/BYTE)
EX_MEM_MemWrite  input  1  1=store, 0=load
EX_MEM_Ext_op  input  1  1=sign-extend loads, 0=zero-extend
EX_MEM_mux5_out  input  32  effective byte address
EX_MEM_mux3_out  input  32  store data
mem_req  output  1  request to data memory
mem_we  output  1  write strobe qualifier
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_be  output  4  byte enables
mem_ready  input  1  memory completes request this cycle
mem_rdata  input  32  read word, valid with mem_ready
stall  output  1  freeze PC/IF/ID/EX and EX/MEM
load_data  output  32  extended load result
load_valid  output  1  load_data valid this cycle
addr_err  output  1  one-cycle misalignment pulse
bad_addr  output  32  last misaligned address
bus_err  output  1  one-cycle timeout pulse

Behaviour:
- Reset (synchronous): state=IDLE; counter=0.
- All registered outputs reset to 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, addr_err, bad_addr, bus_err.
- stall, load_data and load_valid are combinational from state and reset, and are 0 during reset.
- FSM has two states, IDLE and ACCESS.
- IDLE, access detected (EX_MEM_valid && LS_bit!=NONE):
  - Alignment check: WORD needs addr[1:0]==0; HALF needs addr[0]==0; BYTE always aligned.
  - Misaligned: next cycle addr_err=1 and bad_addr=addr. No request is issued, stall stays 0, state stays IDLE.
  - Aligned: stall=1 in the same cycle. At the edge, latch mem_addr, mem_we=MemWrite, mem_be, mem_wdata, size, Ext_op and addr[1:0]. Set mem_req=1 and go to ACCESS.
- Byte enables:
  - WORD: 4'b1111.
  - HALF: addr[1] ? 4'b1100 : 4'b0011.
  - BYTE: 4'b0001 << addr[1:0].
- Write data:
  - WORD: data.
  - HALF: {2{data[15:0]}}.
  - BYTE: {4{data[7:0]}}.
- ACCESS without mem_ready:
  - mem_req and all request fields hold stable; stall=1; counter increments.
  - If TIMEOUT!=0 and counter reaches TIMEOUT-1: bus_err pulses next cycle, mem_req drops, go IDLE, no load_valid.
- ACCESS with mem_ready:
  - stall=0 in that cycle so the pipeline advances at that edge.
  - For a load, load_valid=1 and load_data is driven combinationally in the same cycle.
  - Load lane: WORD uses rdata. HALF uses rdata[16*a1+:16]. BYTE uses rdata[8*a10+:8].
  - Extension is sign or zero per latched Ext_op.
  - For a store, load_valid=0.
  - At the edge: mem_req=0, counter=0, go IDLE.
- Minimum latency: 2 cycles (IDLE issue + ACCESS with ready).
- stall = (IDLE && aligned access) || (ACCESS && !mem_ready && !timeout_hit).
- Boundaries:
  - mem_ready while IDLE is ignored.
  - EX_MEM inputs during ACCESS are ignored; the latched copy is used.
  - A new access in the IDLE cycle directly after completion is accepted (back-to-back).
  - Reset mid-ACCESS aborts: mem_req=0 next cycle, no load_valid, no bus_err.
  - EX_MEM_valid=0 or LS_bit=NONE: no action, no flags.
  - Address bits [31:2] pass through unchanged; no range check.

Decomposition:
- Shared package (mips_mem_pkg): LS size codes NONE/WORD/HALF/BYTE, FSM state encoding, byte-enable and lane-replication functions, load extract/extend function.
- One natural sub-module: mem_load_align (combinational lane select + sign/zero extend), reusable by the writeback path.
- FSM, counter and request registers stay in the top.

Test Plan:
- LW, addr 0x104, ready on 1st ACCESS cycle, rdata 0xDEADBEEF -> mem_addr 0x104, be 1111, stall 1 for 1 cycle, load_valid with load_data 0xDEADBEEF.
- LB, Ext_op=1, addr 0x203, rdata 0x80FF7F01 -> load_data 0xFFFFFF80. Same with Ext_op=0 -> 0x00000080. LHU addr 0x202 -> 0x000080FF.
- SB, addr 0x011, data 0x000000AB -> mem_we 1, be 0010, wdata 0xABABABAB. SH addr 0x012, data 0x1234 -> be 1100, wdata 0x12341234.
- LW addr 0x102 -> addr_err pulse, bad_addr 0x102, no mem_req, stall 0. SH addr 0x101 -> same with 0x101.
- TIMEOUT=4, mem_ready held 0 -> stall 4 cycles, bus_err 1 pulse, mem_req 0, no load_valid. Then reset during a second ACCESS -> mem_req 0 next cycle, no flags.
- Back-to-back SW then LW with ready after 3 wait cycles -> request fields stable across waits, second request issued the cycle after first completion.
